// File: rtl/axi_pkg.sv
// Shared definitions for the AXI RAM slave: response codes and FSM state types.
package axi_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wstate_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_DATA  = 2'd2
  } rstate_t;

endpackage

// File: rtl/axi_ram_array.sv
// 1W1R byte-strobed RAM with a registered read port. A read and a write to the
// same word in one cycle return the old contents (read-first).
module axi_ram_array #(
  parameter int DATA_W     = 128,
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [DEPTH_LOG2-1:0]   waddr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic [DATA_W/8-1:0]     wstrb,
  input  logic                    re,
  input  logic [DEPTH_LOG2-1:0]   raddr,
  output logic [DATA_W-1:0]       rdata
);

  logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  // Byte-masked write and registered read; both non-blocking, so read-first.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi_ram_slave.sv
// AXI4 slave RAM for the 128-bit DRAM master port. Independent write and read
// FSMs share a 1W1R byte-strobed array. All bursts are INCR, 16-byte beats.
//
// Handshake rule on every channel: a transfer happens on the rising clk edge
// where VALID and READY are both 1. A source holds VALID and its payload
// stable until that edge; VALID only drops after a transfer (or on reset).
module axi_ram_slave
  import axi_pkg::*;
#(
  parameter int ADDR_W     = 27,
  parameter int DATA_W     = 128,
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     S_AXI_AWADDR,
  input  logic [7:0]            S_AXI_AWLEN,
  input  logic                  S_AXI_AWVALID,
  output logic                  S_AXI_AWREADY,
  input  logic [DATA_W-1:0]     S_AXI_WDATA,
  input  logic [DATA_W/8-1:0]   S_AXI_WSTRB,
  input  logic                  S_AXI_WLAST,
  input  logic                  S_AXI_WVALID,
  output logic                  S_AXI_WREADY,
  output logic [1:0]            S_AXI_BRESP,
  output logic                  S_AXI_BVALID,
  input  logic                  S_AXI_BREADY,
  input  logic [ADDR_W-1:0]     S_AXI_ARADDR,
  input  logic [7:0]            S_AXI_ARLEN,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  output logic [DATA_W-1:0]     S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  S_AXI_RLAST,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY,
  output logic [1:0]            dbg_wstate,
  output logic [1:0]            dbg_rstate
);

  // Beat counters hold the 16-byte word address; they wrap naturally.
  localparam int CNT_W = ADDR_W - 4;

  wstate_t            w_state;
  logic [CNT_W-1:0]   w_cnt;
  logic [7:0]         w_rem;
  logic               w_err;
  logic               w_oor;
  logic               w_fire;
  logic               w_last_beat;
  logic               w_err_beat;

  rstate_t            r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [7:0]         r_rem;
  logic               r_oor;
  logic               r_oor_q;

  logic               mem_we;
  logic               mem_re;
  logic [DATA_W-1:0]  mem_q;

  assign w_oor       = |w_cnt[CNT_W-1:DEPTH_LOG2];
  assign w_fire      = (w_state == W_DATA) && S_AXI_WREADY && S_AXI_WVALID;
  assign w_last_beat = (w_rem == 8'd0);
  // A beat is bad if its address is out of range or WLAST disagrees with the count.
  assign w_err_beat  = w_oor || (S_AXI_WLAST != w_last_beat);
  assign mem_we      = w_fire && !w_oor;

  assign r_oor       = |r_cnt[CNT_W-1:DEPTH_LOG2];
  assign mem_re      = (r_state == R_FETCH);

  assign dbg_wstate  = w_state;
  assign dbg_rstate  = r_state;

  axi_ram_array #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (w_cnt[DEPTH_LOG2-1:0]),
    .wdata (S_AXI_WDATA),
    .wstrb (S_AXI_WSTRB),
    .re    (mem_re),
    .raddr (r_cnt[DEPTH_LOG2-1:0]),
    .rdata (mem_q)
  );

  // Read data is the registered array word, forced to zero outside R_DATA and
  // for out-of-range beats (the array output itself is never reset).
  always_comb begin
    S_AXI_RDATA = '0;
    if (r_state == R_DATA && !r_oor_q) S_AXI_RDATA = mem_q;
  end

  // Write channel FSM: AW accept, one beat per cycle, then B response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state       <= W_IDLE;
      w_cnt         <= '0;
      w_rem         <= 8'd0;
      w_err         <= 1'b0;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (!S_AXI_AWREADY) begin
            S_AXI_AWREADY <= 1'b1;
          end else if (S_AXI_AWVALID) begin
            w_cnt         <= S_AXI_AWADDR[ADDR_W-1:4];
            w_rem         <= S_AXI_AWLEN;
            w_err         <= 1'b0;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b1;
            w_state       <= W_DATA;
          end
        end
        W_DATA: begin
          if (S_AXI_WVALID) begin
            if (w_err_beat) w_err <= 1'b1;
            if (w_last_beat) begin
              S_AXI_WREADY <= 1'b0;
              S_AXI_BVALID <= 1'b1;
              S_AXI_BRESP  <= (w_err || w_err_beat) ? SLVERR : OKAY;
              w_state      <= W_RESP;
            end else begin
              w_rem <= w_rem - 8'd1;
              w_cnt <= w_cnt + CNT_W'(1);
            end
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            S_AXI_BVALID  <= 1'b0;
            S_AXI_AWREADY <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read channel FSM: AR accept, then alternate FETCH (array read) and DATA.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= R_IDLE;
      r_cnt         <= '0;
      r_rem         <= 8'd0;
      r_oor_q       <= 1'b0;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RRESP   <= OKAY;
      S_AXI_RLAST   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (!S_AXI_ARREADY) begin
            S_AXI_ARREADY <= 1'b1;
          end else if (S_AXI_ARVALID) begin
            r_cnt         <= S_AXI_ARADDR[ADDR_W-1:4];
            r_rem         <= S_AXI_ARLEN;
            S_AXI_ARREADY <= 1'b0;
            r_state       <= R_FETCH;
          end
        end
        R_FETCH: begin
          S_AXI_RVALID <= 1'b1;
          S_AXI_RRESP  <= r_oor ? SLVERR : OKAY;
          S_AXI_RLAST  <= (r_rem == 8'd0);
          r_oor_q      <= r_oor;
          r_state      <= R_DATA;
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
            if (S_AXI_RLAST) begin
              S_AXI_ARREADY <= 1'b1;
              r_state       <= R_IDLE;
            end else begin
              r_cnt   <= r_cnt + CNT_W'(1);
              r_rem   <= r_rem - 8'd1;
              r_state <= R_FETCH;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Self-checking bench for axi_ram_slave: AXI master driver tasks, a byte-level
// memory model, and a scoreboard queue of expected read beats.
module tb_axi_ram_slave;
  import axi_pkg::*;

  logic          clk;
  logic          rst;
  logic [26:0]   awaddr;
  logic [7:0]    awlen;
  logic          awvalid;
  logic          awready;
  logic [127:0]  wdata;
  logic [15:0]   wstrb;
  logic          wlast;
  logic          wvalid;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;
  logic [26:0]   araddr;
  logic [7:0]    arlen;
  logic          arvalid;
  logic          arready;
  logic [127:0]  rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic          rvalid;
  logic          rready;
  logic [1:0]    dbg_wstate;
  logic [1:0]    dbg_rstate;

  int errors = 0;
  int checks = 0;

  logic [127:0] model_mem [0:4095];
  logic [127:0] wbuf [0:15];
  logic [15:0]  sbuf [0:15];
  logic [127:0] exp_q [$];
  logic [1:0]   exp_resp_q [$];

  axi_ram_slave dut (
    .clk           (clk),
    .rst           (rst),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWLEN   (awlen),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WLAST   (wlast),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARLEN   (arlen),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RLAST   (rlast),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .dbg_wstate    (dbg_wstate),
    .dbg_rstate    (dbg_rstate)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write burst driver; updates the model and checks timing and BRESP.
  // bad_last < 0 means WLAST on the correct beat, else WLAST on that beat only.
  task automatic do_write(input logic [26:0] addr, input int len, input int bad_last);
    logic [22:0]  c;
    logic         err;
    logic         wl;
    logic [1:0]   exp_b;
    int           t;
    err = 1'b0;
    @(negedge clk);
    awaddr = addr; awlen = 8'(len); awvalid = 1'b1;
    t = 0;
    while (!awready && t < 50) begin @(negedge clk); t++; end
    checks++;
    if (!awready) begin errors++; $display("FAIL aw_timeout: awready=%0b required 1", awready); end
    @(negedge clk);
    awvalid = 1'b0;
    checks++;
    if (wready !== 1'b1) begin errors++; $display("FAIL wready_after_aw: got %0b required 1", wready); end
    for (int i = 0; i <= len; i++) begin
      wl = (bad_last < 0) ? (i == len) : (i == bad_last);
      wdata = wbuf[i]; wstrb = sbuf[i]; wlast = wl; wvalid = 1'b1;
      t = 0;
      while (!wready && t < 20) begin @(negedge clk); t++; end
      c = addr[26:4] + 23'(i);
      if (|c[22:12]) err = 1'b1;
      else begin
        for (int b = 0; b < 16; b++)
          if (sbuf[i][b]) model_mem[c[11:0]][b*8 +: 8] = wbuf[i][b*8 +: 8];
      end
      if (wl != (i == len)) err = 1'b1;
      @(negedge clk);
      if (i < len) begin
        checks++;
        if (bvalid !== 1'b0 || wready !== 1'b1) begin
          errors++;
          $display("FAIL burst_len: beat %0d bvalid=%0b wready=%0b required 0/1", i, bvalid, wready);
        end
      end
    end
    wvalid = 1'b0; wlast = 1'b0;
    exp_b = err ? SLVERR : OKAY;
    checks++;
    if (bvalid !== 1'b1 || wready !== 1'b0) begin
      errors++; $display("FAIL bvalid_after_last: bvalid=%0b wready=%0b required 1/0", bvalid, wready);
    end
    checks++;
    if (bresp !== exp_b) begin errors++; $display("FAIL bresp: got %0h required %0h", bresp, exp_b); end
    @(negedge clk);
    checks++;
    if (bvalid !== 1'b1 || bresp !== exp_b) begin
      errors++; $display("FAIL b_hold: bvalid=%0b bresp=%0h required 1/%0h", bvalid, bresp, exp_b);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    checks++;
    if (bvalid !== 1'b0 || awready !== 1'b1) begin
      errors++; $display("FAIL b_done: bvalid=%0b awready=%0b required 0/1", bvalid, awready);
    end
  endtask

  // Read burst driver; pushes expected beats, then pops and compares each beat.
  task automatic do_read(input logic [26:0] addr, input int len, input int stall_beat, input int stall_cycles);
    logic [22:0]  c;
    logic [127:0] exp_d;
    logic [1:0]   exp_r;
    logic [127:0] hold_d;
    logic         hold_l;
    int           t;
    for (int i = 0; i <= len; i++) begin
      c = addr[26:4] + 23'(i);
      exp_q.push_back((|c[22:12]) ? 128'd0 : model_mem[c[11:0]]);
      exp_resp_q.push_back((|c[22:12]) ? SLVERR : OKAY);
    end
    @(negedge clk);
    araddr = addr; arlen = 8'(len); arvalid = 1'b1;
    t = 0;
    while (!arready && t < 50) begin @(negedge clk); t++; end
    checks++;
    if (!arready) begin errors++; $display("FAIL ar_timeout: arready=%0b required 1", arready); end
    @(negedge clk);
    arvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b0 || arready !== 1'b0) begin
      errors++; $display("FAIL ar_fetch: rvalid=%0b arready=%0b required 0/0", rvalid, arready);
    end
    for (int i = 0; i <= len; i++) begin
      @(negedge clk);
      t = 0;
      while (!rvalid && t < 20) begin @(negedge clk); t++; end
      checks++;
      if (t != 0) begin errors++; $display("FAIL r_latency: beat %0d extra_cycles=%0d required 0", i, t); end
      exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
      exp_r = (exp_resp_q.size() > 0) ? exp_resp_q.pop_front() : 2'bxx;
      checks++;
      if (rdata !== exp_d) begin errors++; $display("FAIL rdata: beat %0d got %h required %h", i, rdata, exp_d); end
      checks++;
      if (rresp !== exp_r) begin errors++; $display("FAIL rresp: beat %0d got %0h required %0h", i, rresp, exp_r); end
      checks++;
      if (rlast !== (i == len)) begin errors++; $display("FAIL rlast: beat %0d got %0b required %0b", i, rlast, (i == len)); end
      if (i == stall_beat) begin
        hold_d = rdata; hold_l = rlast;
        for (int s = 0; s < stall_cycles; s++) begin
          @(negedge clk);
          checks++;
          if (rvalid !== 1'b1 || rdata !== hold_d || rlast !== hold_l) begin
            errors++;
            $display("FAIL r_stall: cycle %0d rvalid=%0b rdata=%h rlast=%0b required 1/%h/%0b", s, rvalid, rdata, rlast, hold_d, hold_l);
          end
        end
      end
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      checks++;
      if (rvalid !== 1'b0) begin errors++; $display("FAIL r_gap: beat %0d rvalid=%0b required 0", i, rvalid); end
    end
    checks++;
    if (arready !== 1'b1) begin errors++; $display("FAIL r_done: arready=%0b required 1", arready); end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    awaddr = '0; awlen = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'b0 || bresp !== 2'b0 || rresp !== 2'b0 || rdata !== 128'd0) begin
      errors++;
      $display("FAIL reset_outputs: aw=%0b w=%0b b=%0b ar=%0b r=%0b rlast=%0b bresp=%0h rresp=%0h rdata=%h required all 0",
               awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp, rdata);
    end
    checks++;
    if (dbg_wstate !== 2'd0 || dbg_rstate !== 2'd0) begin
      errors++; $display("FAIL reset_state: w=%0d r=%0d required 0/0", dbg_wstate, dbg_rstate);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (awready !== 1'b1 || arready !== 1'b1) begin
      errors++; $display("FAIL ready_after_reset: awready=%0b arready=%0b required 1/1", awready, arready);
    end
  endtask

  task automatic test_single();
    wbuf[0] = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF; sbuf[0] = 16'hFFFF;
    do_write(27'h40, 0, -1);
    do_read(27'h40, 0, -1, 0);
  endtask

  task automatic test_strobe_merge();
    for (int i = 0; i < 4; i++) begin wbuf[i] = {128{1'b1}}; sbuf[i] = 16'hFFFF; end
    do_write(27'h100, 3, -1);
    wbuf[0] = 128'd0; sbuf[0] = 16'h00FF;
    do_write(27'h120, 0, -1);
    do_read(27'h100, 3, -1, 0);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 6; i++) begin
      wbuf[i] = {$urandom(), $urandom(), $urandom(), $urandom()}; sbuf[i] = 16'hFFFF;
    end
    do_write(27'h200, 5, -1);
    do_read(27'h200, 5, 2, 5);
  endtask

  task automatic test_out_of_range();
    wbuf[0] = 128'hA5A5_5A5A_DEAD_BEEF_CAFE_F00D_1234_5678; sbuf[0] = 16'hFFFF;
    do_write(27'h0, 0, -1);
    wbuf[0] = 128'h1111_2222_3333_4444_5555_6666_7777_8888; sbuf[0] = 16'hFFFF;
    do_write(27'h10000, 0, -1);
    do_read(27'h10000, 0, -1, 0);
    do_read(27'h0, 0, -1, 0);
  endtask

  task automatic test_early_wlast();
    for (int i = 0; i < 4; i++) begin wbuf[i] = 128'(i + 32'h77); sbuf[i] = 16'hFFFF; end
    do_write(27'h300, 3, 1);
    do_read(27'h300, 3, -1, 0);
  endtask

  task automatic test_reset_mid_burst();
    int t;
    @(negedge clk);
    araddr = 27'h100; arlen = 8'd3; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    t = 0;
    while (!rvalid && t < 20) begin @(negedge clk); t++; end
    checks++;
    if (rvalid !== 1'b1) begin errors++; $display("FAIL rst_burst_start: rvalid=%0b required 1", rvalid); end
    rst = 1'b0;
    #1;
    checks++;
    if (rvalid !== 1'b0 || arready !== 1'b0 || dbg_rstate !== 2'd0) begin
      errors++; $display("FAIL rst_abort: rvalid=%0b arready=%0b rstate=%0d required 0/0/0", rvalid, arready, dbg_rstate);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (arready !== 1'b1) begin errors++; $display("FAIL rst_release: arready=%0b required 1", arready); end
    exp_q.delete(); exp_resp_q.delete();
    do_read(27'h100, 3, -1, 0);
  endtask

  task automatic test_back_to_back();
    logic [26:0] a [0:2];
    int          l [0:2];
    for (int k = 0; k < 3; k++) begin
      a[k] = 27'($urandom_range(0, 4000)) << 4;
      l[k] = $urandom_range(0, 7);
      for (int i = 0; i <= l[k]; i++) begin
        wbuf[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        sbuf[i] = 16'($urandom_range(0, 16'hFFFF));
      end
      do_write(a[k], l[k], -1);
    end
    for (int k = 0; k < 3; k++) do_read(a[k], l[k], (k == 1) ? 0 : -1, 2);
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_single();
    test_strobe_merge();
    test_backpressure();
    test_out_of_range();
    test_early_wlast();
    test_reset_mid_burst();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left: %0d entries required 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
